// File: rtl/pc_redirect_unit_pkg.sv
// rtl/pc_redirect_unit_pkg.sv - opcode/funct3 constants and FSM state type for the PC redirect unit
package pc_redirect_unit_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_TRAP
  } state_t;

  function automatic logic is_branch(input logic [6:0] opcode);
    return opcode == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// rtl/pc_redirect_unit_if.sv - fetch request handshake between the redirect unit and the fetch stage
interface pc_redirect_unit_if #(
  parameter int AWIDTH = 32
) ();

  logic              fetch_valid_o;
  logic [AWIDTH-1:0] pc_o;
  logic              fetch_ready_i;

  modport master (
    output fetch_valid_o,
    output pc_o,
    input  fetch_ready_i
  );

  modport slave (
    input  fetch_valid_o,
    input  pc_o,
    output fetch_ready_i
  );

endinterface

// File: rtl/pc_redirect_unit_branch_taken.sv
// rtl/pc_redirect_unit_branch_taken.sv - combinational taken decision for branches and jumps
module branch_taken
  import pc_redirect_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       breq,
  input  logic       brlt,
  output logic       taken
);

  // brlt already reflects signed vs unsigned compare, so BLT/BLTU share a term
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ:           taken = breq;
          F3_BNE:           taken = !breq;
          F3_BLT, F3_BLTU:  taken = brlt;
          F3_BGE, F3_BGEU:  taken = !brlt;
          default:          taken = 1'b0;
        endcase
      end
      OPC_JAL, OPC_JALR: taken = 1'b1;
      default:           taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC sequencer with execute-stage redirect, flush and misaligned-target trap
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid_i,
  input  logic [AWIDTH-1:0]    ex_pc_i,
  input  logic [6:0]           opcode_i,
  input  logic [2:0]           funct3_i,
  input  logic                 breq_i,
  input  logic                 brlt_i,
  input  logic [AWIDTH-1:0]    target_i,
  pc_redirect_unit_if.master   fetch,
  output logic                 flush_o,
  output logic                 trap_o,
  output logic [AWIDTH-1:0]    trap_pc_o,
  output logic [31:0]          br_cnt_o,
  output logic [31:0]          taken_cnt_o
);

  state_t            r_state;
  logic [AWIDTH-1:0] r_pc;
  logic              r_fetch_valid;
  logic              r_flush;
  logic              r_trap;
  logic [AWIDTH-1:0] r_trap_pc;
  logic [31:0]       r_br_cnt;
  logic [31:0]       r_taken_cnt;

  logic              w_taken;
  logic              w_ex_taken;
  logic [AWIDTH-1:0] w_target;
  logic              w_misaligned;
  logic              w_handshake;

  branch_taken u_branch_taken (
    .opcode (opcode_i),
    .funct3 (funct3_i),
    .breq   (breq_i),
    .brlt   (brlt_i),
    .taken  (w_taken)
  );

  assign w_target     = (opcode_i == OPC_JALR) ? {target_i[AWIDTH-1:1], 1'b0} : target_i;
  assign w_misaligned = |w_target[1:0];
  assign w_ex_taken   = ex_valid_i && w_taken;
  assign w_handshake  = r_fetch_valid && fetch.fetch_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= BASEADDR;
      r_fetch_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_trap        <= 1'b0;
      r_trap_pc     <= '0;
      r_br_cnt      <= '0;
      r_taken_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state       <= ST_RUN;
          r_fetch_valid <= 1'b1;
        end
        ST_RUN: begin
          if (ex_valid_i && is_branch(opcode_i)) r_br_cnt <= r_br_cnt + 32'd1;
          // a redirect wins over the fetch increment of the same cycle
          if (w_ex_taken && !w_misaligned) begin
            r_state       <= ST_FLUSH;
            r_pc          <= w_target;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b1;
            r_taken_cnt   <= r_taken_cnt + 32'd1;
          end else if (w_ex_taken) begin
            r_state       <= ST_TRAP;
            r_trap_pc     <= ex_pc_i;
            r_trap        <= 1'b1;
            r_fetch_valid <= 1'b0;
          end else if (w_handshake) begin
            r_pc <= r_pc + AWIDTH'(4);
          end
        end
        ST_FLUSH: begin
          r_state       <= ST_RUN;
          r_flush       <= 1'b0;
          r_fetch_valid <= 1'b1;
        end
        ST_TRAP: begin
          r_fetch_valid <= 1'b0;
          r_flush       <= 1'b0;
          r_trap        <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fetch.fetch_valid_o = r_fetch_valid;
  assign fetch.pc_o          = r_pc;
  assign flush_o             = r_flush;
  assign trap_o              = r_trap;
  assign trap_pc_o           = r_trap_pc;
  assign br_cnt_o            = r_br_cnt;
  assign taken_cnt_o         = r_taken_cnt;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - scenario tasks with a fetch-PC scoreboard for pc_redirect_unit
module tb_pc_redirect_unit;
  import pc_redirect_unit_pkg::*;

  localparam logic [31:0] B = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic        breq_i;
  logic        brlt_i;
  logic [31:0] target_i;
  logic        flush_o;
  logic        trap_o;
  logic [31:0] trap_pc_o;
  logic [31:0] br_cnt_o;
  logic [31:0] taken_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  pc_redirect_unit_if #(.AWIDTH(32)) fif ();

  pc_redirect_unit #(.AWIDTH(32), .BASEADDR(B)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid_i  (ex_valid_i),
    .ex_pc_i     (ex_pc_i),
    .opcode_i    (opcode_i),
    .funct3_i    (funct3_i),
    .breq_i      (breq_i),
    .brlt_i      (brlt_i),
    .target_i    (target_i),
    .fetch       (fif),
    .flush_o     (flush_o),
    .trap_o      (trap_o),
    .trap_pc_o   (trap_pc_o),
    .br_cnt_o    (br_cnt_o),
    .taken_cnt_o (taken_cnt_o)
  );

  always #5 clk = ~clk;

  // fetch scoreboard: every accepted fetch must match the next expected PC
  always begin : fetch_mon
    logic [31:0] want;
    @(negedge clk);
    #3;
    if (!reset && fif.fetch_valid_o && fif.fetch_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected pc=%h required none", fif.pc_o);
      end else begin
        want = exp_q.pop_front();
        if (fif.pc_o !== want) begin
          errors++;
          $display("FAIL fetch_pc got=%h required=%h", fif.pc_o, want);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic eq, input logic lt, input logic [31:0] tgt, input logic [31:0] pc);
    ex_valid_i = v;
    opcode_i   = op;
    funct3_i   = f3;
    breq_i     = eq;
    brlt_i     = lt;
    target_i   = tgt;
    ex_pc_i    = pc;
  endtask

  task automatic do_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_fetches got=%0d required=0", exp_q.size());
    end
    reset = 1'b1;
    set_ex(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    fif.fetch_ready_i = 1'b1;
    cyc();
    cyc();
    exp_q.delete();
  endtask

  task automatic start_run();
    do_reset();
    reset = 1'b0;
    checks++;
    if (fif.fetch_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid got=%b required=0", fif.fetch_valid_o);
    end
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (fif.fetch_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b required=0", fif.fetch_valid_o); end
    if (fif.pc_o !== B) begin errors++; $display("FAIL rst_pc got=%h required=%h", fif.pc_o, B); end
    if (flush_o !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b required=0", flush_o); end
    if (trap_o !== 1'b0) begin errors++; $display("FAIL rst_trap got=%b required=0", trap_o); end
    if (trap_pc_o !== 32'd0) begin errors++; $display("FAIL rst_trap_pc got=%h required=0", trap_pc_o); end
    if (br_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_br_cnt got=%0d required=0", br_cnt_o); end
    if (taken_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_taken_cnt got=%0d required=0", taken_cnt_o); end
  endtask

  task automatic test_sequential();
    start_run();
    exp_q.push_back(B);
    exp_q.push_back(B + 32'd4);
    exp_q.push_back(B + 32'd8);
    repeat (3) begin
      checks++;
      if (fif.fetch_valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid got=%b required=1", fif.fetch_valid_o); end
      cyc();
    end
    fif.fetch_ready_i = 1'b0;
    checks += 2;
    if (fif.pc_o !== B + 32'd12) begin errors++; $display("FAIL seq_pc got=%h required=%h", fif.pc_o, B + 32'd12); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL seq_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_beq_redirect();
    start_run();
    exp_q.push_back(B);
    set_ex(1'b1, OPC_BRANCH, F3_BEQ, 1'b1, 1'b0, B + 32'h40, B);
    cyc();
    set_ex(1'b1, OPC_JAL, 3'd0, 1'b0, 1'b0, B + 32'h2, B + 32'h4);
    checks += 4;
    if (flush_o !== 1'b1) begin errors++; $display("FAIL beq_flush_n1 got=%b required=1", flush_o); end
    if (fif.fetch_valid_o !== 1'b0) begin errors++; $display("FAIL beq_valid_n1 got=%b required=0", fif.fetch_valid_o); end
    if (taken_cnt_o !== 32'd1) begin errors++; $display("FAIL beq_taken_cnt got=%0d required=1", taken_cnt_o); end
    if (br_cnt_o !== 32'd1) begin errors++; $display("FAIL beq_br_cnt got=%0d required=1", br_cnt_o); end
    cyc();
    set_ex(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks += 5;
    if (flush_o !== 1'b0) begin errors++; $display("FAIL beq_flush_n2 got=%b required=0", flush_o); end
    if (fif.fetch_valid_o !== 1'b1) begin errors++; $display("FAIL beq_valid_n2 got=%b required=1", fif.fetch_valid_o); end
    if (fif.pc_o !== B + 32'h40) begin errors++; $display("FAIL beq_pc_n2 got=%h required=%h", fif.pc_o, B + 32'h40); end
    if (trap_o !== 1'b0) begin errors++; $display("FAIL beq_wrongpath_trap got=%b required=0", trap_o); end
    if (taken_cnt_o !== 32'd1) begin errors++; $display("FAIL beq_flush_ignored got=%0d required=1", taken_cnt_o); end
    exp_q.push_back(B + 32'h40);
    cyc();
    fif.fetch_ready_i = 1'b0;
    checks += 2;
    if (fif.pc_o !== B + 32'h44) begin errors++; $display("FAIL beq_pc_next got=%h required=%h", fif.pc_o, B + 32'h44); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL beq_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_bne_not_taken();
    start_run();
    exp_q.push_back(B);
    set_ex(1'b1, OPC_BRANCH, F3_BNE, 1'b1, 1'b0, B + 32'h40, B);
    cyc();
    set_ex(1'b1, 7'b0110011, 3'd0, 1'b1, 1'b1, B + 32'h80, B + 32'h4);
    checks += 5;
    if (flush_o !== 1'b0) begin errors++; $display("FAIL bne_flush got=%b required=0", flush_o); end
    if (fif.fetch_valid_o !== 1'b1) begin errors++; $display("FAIL bne_valid got=%b required=1", fif.fetch_valid_o); end
    if (fif.pc_o !== B + 32'h4) begin errors++; $display("FAIL bne_pc got=%h required=%h", fif.pc_o, B + 32'h4); end
    if (br_cnt_o !== 32'd1) begin errors++; $display("FAIL bne_br_cnt got=%0d required=1", br_cnt_o); end
    if (taken_cnt_o !== 32'd0) begin errors++; $display("FAIL bne_taken_cnt got=%0d required=0", taken_cnt_o); end
    exp_q.push_back(B + 32'h4);
    cyc();
    set_ex(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    fif.fetch_ready_i = 1'b0;
    checks += 4;
    if (fif.pc_o !== B + 32'h8) begin errors++; $display("FAIL alu_pc got=%h required=%h", fif.pc_o, B + 32'h8); end
    if (flush_o !== 1'b0) begin errors++; $display("FAIL alu_flush got=%b required=0", flush_o); end
    if (br_cnt_o !== 32'd1) begin errors++; $display("FAIL alu_br_cnt got=%0d required=1", br_cnt_o); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL bne_drain got=%0d required=0", exp_q.size()); end
  endtask

  typedef struct {
    logic [2:0] f3;
    logic       eq;
    logic       lt;
    logic       tk;
  } br_vec_t;

  task automatic test_branch_table();
    br_vec_t     tbl[10];
    logic [31:0] exp_pc;
    int          n_br;
    int          n_tk;
    tbl = '{'{F3_BEQ,  1'b0, 1'b0, 1'b0}, '{F3_BLT,  1'b0, 1'b1, 1'b1},
            '{F3_BLT,  1'b1, 1'b0, 1'b0}, '{F3_BGE,  1'b0, 1'b0, 1'b1},
            '{F3_BGE,  1'b0, 1'b1, 1'b0}, '{F3_BLTU, 1'b0, 1'b1, 1'b1},
            '{F3_BGEU, 1'b0, 1'b1, 1'b0}, '{F3_BGEU, 1'b1, 1'b0, 1'b1},
            '{3'b010,  1'b1, 1'b1, 1'b0}, '{F3_BNE,  1'b0, 1'b0, 1'b1}};
    start_run();
    exp_pc = B;
    n_br = 0;
    n_tk = 0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(exp_pc);
      set_ex(1'b1, OPC_BRANCH, tbl[i].f3, tbl[i].eq, tbl[i].lt, exp_pc + 32'h100, exp_pc);
      cyc();
      set_ex(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      n_br++;
      checks++;
      if (flush_o !== tbl[i].tk) begin errors++; $display("FAIL tbl_flush idx=%0d got=%b required=%b", i, flush_o, tbl[i].tk); end
      if (tbl[i].tk) begin
        n_tk++;
        exp_pc = exp_pc + 32'h100;
        cyc();
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
      checks++;
      if (fif.pc_o !== exp_pc) begin errors++; $display("FAIL tbl_pc idx=%0d got=%h required=%h", i, fif.pc_o, exp_pc); end
    end
    fif.fetch_ready_i = 1'b0;
    checks += 3;
    if (br_cnt_o !== 32'(n_br)) begin errors++; $display("FAIL tbl_br_cnt got=%0d required=%0d", br_cnt_o, n_br); end
    if (taken_cnt_o !== 32'(n_tk)) begin errors++; $display("FAIL tbl_taken_cnt got=%0d required=%0d", taken_cnt_o, n_tk); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL tbl_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_jalr_and_trap();
    start_run();
    exp_q.push_back(B);
    set_ex(1'b1, OPC_JALR, 3'd0, 1'b0, 1'b0, B + 32'h81, B);
    cyc();
    set_ex(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++;
    if (flush_o !== 1'b1) begin errors++; $display("FAIL jalr_flush got=%b required=1", flush_o); end
    cyc();
    checks++;
    if (fif.pc_o !== B + 32'h80) begin errors++; $display("FAIL jalr_pc got=%h required=%h", fif.pc_o, B + 32'h80); end
    exp_q.push_back(B + 32'h80);
    set_ex(1'b1, OPC_JAL, 3'd0, 1'b0, 1'b0, B + 32'h42, B + 32'h80);
    cyc();
    set_ex(1'b1, OPC_BRANCH, F3_BEQ, 1'b1, 1'b0, B + 32'h100, B + 32'h84);
    checks += 6;
    if (trap_o !== 1'b1) begin errors++; $display("FAIL trap_set got=%b required=1", trap_o); end
    if (trap_pc_o !== B + 32'h80) begin errors++; $display("FAIL trap_pc got=%h required=%h", trap_pc_o, B + 32'h80); end
    if (fif.fetch_valid_o !== 1'b0) begin errors++; $display("FAIL trap_valid got=%b required=0", fif.fetch_valid_o); end
    if (flush_o !== 1'b0) begin errors++; $display("FAIL trap_flush got=%b required=0", flush_o); end
    if (fif.pc_o !== B + 32'h80) begin errors++; $display("FAIL trap_pc_hold got=%h required=%h", fif.pc_o, B + 32'h80); end
    if (taken_cnt_o !== 32'd1) begin errors++; $display("FAIL trap_taken_cnt got=%0d required=1", taken_cnt_o); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks += 2;
      if (trap_o !== 1'b1) begin errors++; $display("FAIL trap_sticky cyc=%0d got=%b required=1", i, trap_o); end
      if (fif.fetch_valid_o !== 1'b0) begin errors++; $display("FAIL trap_no_fetch cyc=%0d got=%b required=0", i, fif.fetch_valid_o); end
    end
    checks++;
    if (br_cnt_o !== 32'd0) begin errors++; $display("FAIL trap_br_cnt got=%0d required=0", br_cnt_o); end
    do_reset();
    checks += 3;
    if (trap_o !== 1'b0) begin errors++; $display("FAIL trap_reset got=%b required=0", trap_o); end
    if (trap_pc_o !== 32'd0) begin errors++; $display("FAIL trap_pc_reset got=%h required=0", trap_pc_o); end
    if (fif.pc_o !== B) begin errors++; $display("FAIL trap_reset_pc got=%h required=%h", fif.pc_o, B); end
  endtask

  task automatic test_stall_and_flush_reset();
    start_run();
    fif.fetch_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks += 2;
      if (fif.pc_o !== B) begin errors++; $display("FAIL stall_pc cyc=%0d got=%h required=%h", i, fif.pc_o, B); end
      if (fif.fetch_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid cyc=%0d got=%b required=1", i, fif.fetch_valid_o); end
    end
    set_ex(1'b1, OPC_BRANCH, F3_BEQ, 1'b1, 1'b0, B + 32'h200, B);
    cyc();
    set_ex(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++;
    if (flush_o !== 1'b1) begin errors++; $display("FAIL stall_flush got=%b required=1", flush_o); end
    cyc();
    checks += 2;
    if (fif.pc_o !== B + 32'h200) begin errors++; $display("FAIL stall_redirect_pc got=%h required=%h", fif.pc_o, B + 32'h200); end
    if (flush_o !== 1'b0) begin errors++; $display("FAIL stall_flush_end got=%b required=0", flush_o); end
    fif.fetch_ready_i = 1'b1;
    exp_q.push_back(B + 32'h200);
    cyc();
    fif.fetch_ready_i = 1'b0;
    set_ex(1'b1, OPC_BRANCH, F3_BGE, 1'b0, 1'b0, B + 32'h300, B + 32'h4);
    cyc();
    set_ex(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++;
    if (flush_o !== 1'b1) begin errors++; $display("FAIL flush_before_reset got=%b required=1", flush_o); end
    reset = 1'b1;
    cyc();
    checks += 4;
    if (fif.fetch_valid_o !== 1'b0) begin errors++; $display("FAIL flushrst_valid got=%b required=0", fif.fetch_valid_o); end
    if (flush_o !== 1'b0) begin errors++; $display("FAIL flushrst_flush got=%b required=0", flush_o); end
    if (fif.pc_o !== B) begin errors++; $display("FAIL flushrst_pc got=%h required=%h", fif.pc_o, B); end
    if (taken_cnt_o !== 32'd0) begin errors++; $display("FAIL flushrst_taken got=%0d required=0", taken_cnt_o); end
    reset = 1'b0;
    cyc();
    checks += 3;
    if (fif.fetch_valid_o !== 1'b1) begin errors++; $display("FAIL flushrst_run got=%b required=1", fif.fetch_valid_o); end
    if (fif.pc_o !== B) begin errors++; $display("FAIL flushrst_run_pc got=%h required=%h", fif.pc_o, B); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_pc_wrap();
    start_run();
    exp_q.push_back(B);
    set_ex(1'b1, OPC_JAL, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFC, B);
    cyc();
    set_ex(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    checks++;
    if (fif.pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target got=%h required=fffffffc", fif.pc_o); end
    exp_q.push_back(32'hFFFF_FFFC);
    cyc();
    fif.fetch_ready_i = 1'b0;
    checks += 2;
    if (fif.pc_o !== 32'd0) begin errors++; $display("FAIL wrap_pc got=%h required=0", fif.pc_o); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain got=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_beq_redirect();
    test_bne_not_taken();
    test_branch_table();
    test_jalr_and_trap();
    test_stall_and_flush_reset();
    test_pc_wrap();
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
